// File: rtl/uart_fifo_ctrl_if.sv
// uart_fifo_ctrl_if: request/status bundle between the UART rx/tx logic
// (master) and the FIFO pointer/flag controller (slave).
//   push, pop, flush, clr_err      master -> slave requests
//   ram_wr_en/ram_wr_address       slave -> RAM write port
//   ram_rd_en/ram_rd_address       slave -> RAM read port
//   rd_valid                       RAM read_dout holds popped data
//   full/empty/almost_*/count      occupancy status
//   overflow/underflow             sticky error flags
interface uart_fifo_ctrl_if #(
  parameter int ADDRESSWIDTH = 4
);
  logic                    push;
  logic                    pop;
  logic                    flush;
  logic                    clr_err;
  logic                    ram_wr_en;
  logic [ADDRESSWIDTH-1:0] ram_wr_address;
  logic                    ram_rd_en;
  logic [ADDRESSWIDTH-1:0] ram_rd_address;
  logic                    rd_valid;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [ADDRESSWIDTH:0]   count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output push, pop, flush, clr_err,
    input  ram_wr_en, ram_wr_address, ram_rd_en, ram_rd_address, rd_valid,
           full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, clr_err,
    output ram_wr_en, ram_wr_address, ram_rd_en, ram_rd_address, rd_valid,
           full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: pointer and flag controller for the UART FIFO. Drives the
// write/read ports of an external simple dual-port RAM; carries no data.
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   fifo_if  slave side of uart_fifo_ctrl_if (requests in, RAM drive and
//            status out)
// DEPTH must equal 2**ADDRESSWIDTH so the pointers wrap naturally.
module uart_fifo_ctrl #(
  parameter int DEPTH        = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int AF_LEVEL     = 14,
  parameter int AE_LEVEL     = 2
) (
  input  logic              clk,
  input  logic              rst,
  uart_fifo_ctrl_if.slave   fifo_if
);
  localparam int AW    = ADDRESSWIDTH;
  localparam int CNT_W = ADDRESSWIDTH + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             rd_valid_q;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;

  // Acceptance looks only at the registered flags, so a pop cannot make room
  // for a same-cycle push and a push cannot feed a same-cycle pop. Gating
  // with rst keeps the RAM ports quiet while reset is held.
  assign wr_acc = fifo_if.push & ~full_q  & ~fifo_if.flush & ~rst;
  assign rd_acc = fifo_if.pop  & ~empty_q & ~fifo_if.flush & ~rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_if.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Flags decode from the next count and are registered alongside it, so
  // they are never a cycle behind. Flush lands on count 0, which decodes to
  // the same values reset forces.
  always_comb begin
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CNT_W'(AF_LEVEL));
    aempty_d = (count_d <= CNT_W'(AE_LEVEL));
  end

  // Sticky errors: a fresh error beats a same-cycle clear.
  always_comb begin
    ovf_d = (fifo_if.push & full_q  & ~fifo_if.flush) | (ovf_q & ~fifo_if.clr_err);
    unf_d = (fifo_if.pop  & empty_q & ~fifo_if.flush) | (unf_q & ~fifo_if.clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      rd_valid_q <= rd_acc;  // RAM read latency is one cycle
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign fifo_if.ram_wr_en      = wr_acc;
  assign fifo_if.ram_wr_address = wr_ptr_q;
  assign fifo_if.ram_rd_en      = rd_acc;
  assign fifo_if.ram_rd_address = rd_ptr_q;
  assign fifo_if.rd_valid       = rd_valid_q;
  assign fifo_if.full           = full_q;
  assign fifo_if.empty          = empty_q;
  assign fifo_if.almost_full    = afull_q;
  assign fifo_if.almost_empty   = aempty_q;
  assign fifo_if.count          = count_q;
  assign fifo_if.overflow       = ovf_q;
  assign fifo_if.underflow      = unf_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: table-driven bench for uart_fifo_ctrl with a behavioural
// RAM and a data scoreboard (accepted push data queued, compared on rd_valid).
module tb_uart_fifo_ctrl;
  typedef struct {
    logic       push, pop, flush, clr;
    logic [7:0] din;
    logic [4:0] cnt;   // expected count after the edge
    logic       rdv;   // expected rd_valid after the edge
    logic       ovf, unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_fifo_ctrl_if #(.ADDRESSWIDTH(4)) bus();

  uart_fifo_ctrl #(.DEPTH(16), .ADDRESSWIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .fifo_if(bus)
  );

  int errs = 0;
  int checks = 0;
  logic [7:0] mem [16];
  logic [7:0] dout;
  logic [7:0] sb [$];
  logic [4:0] mcnt;
  logic [3:0] ewp, erp;
  vec_t vecs [$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic p, logic q, logic f, logic c, logic [7:0] d,
                              logic [4:0] cn, logic rv, logic ov, logic un);
    vec_t v;
    v.push = p; v.pop = q; v.flush = f; v.clr = c; v.din = d;
    v.cnt = cn; v.rdv = rv; v.ovf = ov; v.unf = un;
    return v;
  endfunction

  task automatic step(vec_t v);
    logic wa, ra, wen, ren;
    logic [3:0] wad, rad;
    logic [3:0] eflags;
    @(negedge clk);
    bus.push = v.push; bus.pop = v.pop; bus.flush = v.flush; bus.clr_err = v.clr;
    #1;
    wa = v.push & (mcnt != 5'd16) & ~v.flush;
    ra = v.pop  & (mcnt != 5'd0)  & ~v.flush;
    chk("ram_wr_en", 32'(bus.ram_wr_en), 32'(wa));
    chk("ram_rd_en", 32'(bus.ram_rd_en), 32'(ra));
    if (wa) chk("ram_wr_address", 32'(bus.ram_wr_address), 32'(ewp));
    if (ra) chk("ram_rd_address", 32'(bus.ram_rd_address), 32'(erp));
    wen = bus.ram_wr_en; ren = bus.ram_rd_en;
    wad = bus.ram_wr_address; rad = bus.ram_rd_address;
    if (wa) sb.push_back(v.din);
    @(posedge clk);
    if (wen) mem[wad] = v.din;
    if (ren) dout = mem[rad];
    if (v.flush) begin
      ewp = '0; erp = '0; sb.delete();
    end else begin
      ewp = ewp + 4'(wa); erp = erp + 4'(ra);
    end
    #2;
    eflags = {v.cnt == 5'd16, v.cnt == 5'd0, v.cnt >= 5'd14, v.cnt <= 5'd2};
    chk("count", 32'(bus.count), 32'(v.cnt));
    chk("flags{full,empty,af,ae}",
        32'({bus.full, bus.empty, bus.almost_full, bus.almost_empty}), 32'(eflags));
    chk("rd_valid", 32'(bus.rd_valid), 32'(v.rdv));
    chk("overflow", 32'(bus.overflow), 32'(v.ovf));
    chk("underflow", 32'(bus.underflow), 32'(v.unf));
    mcnt = v.cnt;
    if (v.rdv && bus.rd_valid) begin
      if (sb.size() == 0) chk("scoreboard_nonempty", 32'(0), 32'(1));
      else chk("read_dout", 32'(dout), 32'(sb.pop_front()));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Stimulus table
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1,0,0,0,8'(i),5'(i+1),0,0,0));
    vecs.push_back(mk(1,1,0,0,8'hEE,15,1,1,0));               // push at full rejected
    for (int i = 1; i < 16; i++) vecs.push_back(mk(0,1,0,0,0,5'(15-i),1,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,0));
    vecs.push_back(mk(1,1,0,0,8'h55,1,0,1,1));                // pop at empty rejected
    vecs.push_back(mk(0,0,0,1,0,1,0,0,0));                    // clr_err
    vecs.push_back(mk(0,1,0,0,0,0,1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,0,0));                    // flush: pointers to 0
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0,8'(8'hA+i),5'(i+1),0,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,0,0,0,5'(3-i),1,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,1));                    // pop on empty
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1,0,0,0,8'(8'h20+i),5'(i+1),0,0,1));
    for (int i = 0; i < 40; i++) vecs.push_back(mk(1,1,0,0,8'(8'h40+i),5,1,0,1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0,8'(8'h80+i),5'(6+i),0,0,1));
    vecs.push_back(mk(1,1,1,0,8'hFF,0,0,0,1));                // flush beats push/pop
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1));

    // Reset state, with push held to show the RAM write port stays off
    bus.push = 1'b1; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    dout = '0; mcnt = '0; ewp = '0; erp = '0;
    #12;
    chk("reset_ram_wr_en", 32'(bus.ram_wr_en), 32'(0));
    chk("reset_count", 32'(bus.count), 32'(0));
    chk("reset_flags", 32'({bus.full, bus.empty, bus.almost_full, bus.almost_empty}), 32'(4'b0101));
    chk("reset_err", 32'({bus.overflow, bus.underflow, bus.rd_valid}), 32'(0));
    bus.push = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Asynchronous reset between edges abandons an in-flight read
    for (int i = 0; i < 3; i++) step(mk(1,0,0,0,8'(8'h90+i),5'(i+1),0,0,1));
    step(mk(1,1,0,0,8'h77,3,1,0,1));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(bus.count), 32'(0));
    chk("async_rst_flags", 32'({bus.full, bus.empty, bus.almost_full, bus.almost_empty}), 32'(4'b0101));
    chk("async_rst_rd_valid", 32'(bus.rd_valid), 32'(0));
    chk("async_rst_ram_en", 32'({bus.ram_wr_en, bus.ram_rd_en}), 32'(0));
    chk("async_rst_underflow", 32'(bus.underflow), 32'(0));
    @(negedge clk);
    bus.push = 1'b0; bus.pop = 1'b0;
    rst = 1'b0;
    mcnt = '0; ewp = '0; erp = '0; sb.delete();

    // Fresh overflow in the same cycle as clr_err keeps the flag set
    for (int i = 0; i < 16; i++) step(mk(1,0,0,0,8'(8'hC0+i),5'(i+1),0,0,0));
    step(mk(1,0,0,1,8'h11,16,0,1,0));
    step(mk(0,0,0,1,0,16,0,0,0));
    step(mk(0,0,0,0,0,16,0,0,0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
